// File: rtl/ddr3_ui_responder.sv
// rtl/ddr3_ui_responder.sv - DDR3 UI responder backed by an on-chip 512-bit array
//
// Stands in for the DDR3 memory controller user interface so the RAM tester
// data path can run without a real controller. Commands and write data are
// queued in two small FIFOs, an in-order executor applies them to the array,
// and read results come back through a fixed-latency delay line.
//
// Ports:
//   clk, reset            UI clock, synchronous active-high reset
//   calib_done            high CALIB_CYCLES cycles after reset release
//   app_en/app_cmd/app_addr/app_rdy            command channel (000 wr, 001 rd)
//   app_wdf_wren/app_wdf_data/app_wdf_end/app_wdf_mask/app_wdf_rdy  write data
//   app_rd_data/app_rd_data_valid/app_rd_data_end                   read return
//   err_cmd               sticky: an illegal command was executed
//
// Optional build macro: DDR3_UI_RESP_BACKPRESSURE_EN adds LFSR-driven
// throttling of both ready outputs and of the executor.

module ddr3_ui_responder #(
   parameter int MEM_AW       = 8,
   parameter int ADDR_LSB     = 3,
   parameter int CMD_DEPTH    = 4,
   parameter int WDF_DEPTH    = 4,
   parameter int RD_LATENCY   = 4,
   parameter int CALIB_CYCLES = 16
) (
   input  logic         clk,
   input  logic         reset,
   output logic         calib_done,
   input  logic         app_en,
   input  logic [2:0]   app_cmd,
   input  logic [28:0]  app_addr,
   output logic         app_rdy,
   input  logic         app_wdf_wren,
   input  logic [511:0] app_wdf_data,
   input  logic         app_wdf_end,
   input  logic [63:0]  app_wdf_mask,
   output logic         app_wdf_rdy,
   output logic [511:0] app_rd_data,
   output logic         app_rd_data_valid,
   output logic         app_rd_data_end,
   output logic         err_cmd
);

   localparam int CPW  = $clog2(CMD_DEPTH);
   localparam int WPW  = $clog2(WDF_DEPTH);
   localparam int CCW  = CPW + 1;
   localparam int WCW  = WPW + 1;
   localparam int CALW = $clog2(CALIB_CYCLES + 1);

   localparam logic [CCW-1:0]  CMD_FULL = CCW'(CMD_DEPTH);
   localparam logic [WCW-1:0]  WDF_FULL = WCW'(WDF_DEPTH);
   localparam logic [CALW-1:0] CAL_LAST = CALW'(CALIB_CYCLES - 1);

   typedef enum logic [0:0] {ST_IDLE, ST_EXEC} state_t;

   state_t              state_q, state_d;
   logic [CALW-1:0]     cal_cnt_q, cal_cnt_d;
   logic                calib_done_q, calib_done_d;
   logic                err_cmd_q, err_cmd_d;

   logic [31:0]         cmd_mem_q [CMD_DEPTH];
   logic [CPW-1:0]      cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
   logic [CCW-1:0]      cmd_cnt_q, cmd_cnt_d;

   logic [511:0]        wdf_data_q [WDF_DEPTH];
   logic [63:0]         wdf_mask_q [WDF_DEPTH];
   logic [WPW-1:0]      wdf_wp_q, wdf_wp_d, wdf_rp_q, wdf_rp_d;
   logic [WCW-1:0]      wdf_cnt_q, wdf_cnt_d;

   logic [511:0]        mem_q [2**MEM_AW];

   // Stage 0 of the delay line is the registered array read itself.
   logic [RD_LATENCY-2:0] rd_vld_q, rd_vld_d;
   logic [511:0]        rd_pipe_q [RD_LATENCY-1];
   logic [511:0]        rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;

   logic                bp_cmd, bp_wdf, exec_stall;
   logic                cmd_push, cmd_pop, wdf_push, wdf_pop;
   logic                mem_we, rd_launch;
   logic [2:0]          head_cmd;
   logic [28:0]         head_addr;
   logic [MEM_AW-1:0]   head_idx;
   logic                unused_bits;

`ifdef DDR3_UI_RESP_BACKPRESSURE_EN
   logic [15:0]         lfsr_q, lfsr_d;

   // Fibonacci LFSR, taps 16/14/13/11: maximal length, never reaches zero.
   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   always_ff @(posedge clk) begin
      if (reset) lfsr_q <= 16'hACE1;
      else       lfsr_q <= lfsr_d;
   end

   assign bp_cmd     = (lfsr_q[1:0] == 2'b00);
   assign bp_wdf     = (lfsr_q[3:2] == 2'b00);
   assign exec_stall = (lfsr_q[5:4] == 2'b00);
`else
   assign bp_cmd     = 1'b0;
   assign bp_wdf     = 1'b0;
   assign exec_stall = 1'b0;
`endif

   // Ready depends only on registered state, never on the strobes.
   assign app_rdy     = calib_done_q & (cmd_cnt_q < CMD_FULL) & ~bp_cmd;
   assign app_wdf_rdy = calib_done_q & (wdf_cnt_q < WDF_FULL) & ~bp_wdf;
   assign cmd_push    = app_en & app_rdy;
   assign wdf_push    = app_wdf_wren & app_wdf_rdy;

   assign head_cmd  = cmd_mem_q[cmd_rp_q][31:29];
   assign head_addr = cmd_mem_q[cmd_rp_q][28:0];
   assign head_idx  = head_addr[ADDR_LSB+MEM_AW-1:ADDR_LSB];

   // Every beat is a full word, so the end flag carries no information; the
   // address bits outside the word index are dropped by design.
   assign unused_bits = ^{app_wdf_end, head_addr};

   always_comb begin
      cal_cnt_d    = cal_cnt_q;
      calib_done_d = calib_done_q;
      if (!calib_done_q) begin
         cal_cnt_d = cal_cnt_q + CALW'(1);
         if (cal_cnt_q == CAL_LAST) calib_done_d = 1'b1;
      end
   end

   always_comb begin
      cmd_pop   = 1'b0;
      wdf_pop   = 1'b0;
      mem_we    = 1'b0;
      rd_launch = 1'b0;
      err_cmd_d = err_cmd_q;
      if (state_q == ST_EXEC && cmd_cnt_q != '0 && !exec_stall) begin
         case (head_cmd)
            3'b000: begin
               // A write waits for its own data beat; nothing behind it may pass.
               if (wdf_cnt_q != '0) begin
                  mem_we  = 1'b1;
                  cmd_pop = 1'b1;
                  wdf_pop = 1'b1;
               end
            end
            3'b001: begin
               rd_launch = 1'b1;
               cmd_pop   = 1'b1;
            end
            default: begin
               cmd_pop   = 1'b1;
               err_cmd_d = 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      cmd_wp_d  = cmd_wp_q + CPW'(cmd_push);
      cmd_rp_d  = cmd_rp_q + CPW'(cmd_pop);
      cmd_cnt_d = cmd_cnt_q + CCW'(cmd_push) - CCW'(cmd_pop);
      wdf_wp_d  = wdf_wp_q + WPW'(wdf_push);
      wdf_rp_d  = wdf_rp_q + WPW'(wdf_pop);
      wdf_cnt_d = wdf_cnt_q + WCW'(wdf_push) - WCW'(wdf_pop);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (cmd_cnt_q != '0) state_d = ST_EXEC;
         ST_EXEC: state_d = (cmd_cnt_d != '0) ? ST_EXEC : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rd_vld_d[0] = rd_launch;
      for (int i = 1; i < RD_LATENCY - 1; i++) rd_vld_d[i] = rd_vld_q[i-1];
      rd_valid_d = rd_vld_q[RD_LATENCY-2];
      rd_data_d  = rd_vld_q[RD_LATENCY-2] ? rd_pipe_q[RD_LATENCY-2] : rd_data_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cal_cnt_q    <= '0;
         calib_done_q <= 1'b0;
         err_cmd_q    <= 1'b0;
         cmd_wp_q     <= '0;
         cmd_rp_q     <= '0;
         cmd_cnt_q    <= '0;
         wdf_wp_q     <= '0;
         wdf_rp_q     <= '0;
         wdf_cnt_q    <= '0;
         rd_vld_q     <= '0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         cal_cnt_q    <= cal_cnt_d;
         calib_done_q <= calib_done_d;
         err_cmd_q    <= err_cmd_d;
         cmd_wp_q     <= cmd_wp_d;
         cmd_rp_q     <= cmd_rp_d;
         cmd_cnt_q    <= cmd_cnt_d;
         wdf_wp_q     <= wdf_wp_d;
         wdf_rp_q     <= wdf_rp_d;
         wdf_cnt_q    <= wdf_cnt_d;
         rd_vld_q     <= rd_vld_d;
         rd_valid_q   <= rd_valid_d;
         rd_data_q    <= rd_data_d;
      end
   end

   // Storage without reset: FIFO slots are qualified by the counts, and the
   // array deliberately keeps its contents across reset.
   always_ff @(posedge clk) begin
      if (cmd_push) cmd_mem_q[cmd_wp_q] <= {app_cmd, app_addr};
      if (wdf_push) begin
         wdf_data_q[wdf_wp_q] <= app_wdf_data;
         wdf_mask_q[wdf_wp_q] <= app_wdf_mask;
      end
      if (mem_we) begin
         for (int b = 0; b < 64; b++) begin
            if (!wdf_mask_q[wdf_rp_q][b])
               mem_q[head_idx][8*b +: 8] <= wdf_data_q[wdf_rp_q][8*b +: 8];
         end
      end
      rd_pipe_q[0] <= mem_q[head_idx];
      for (int i = 1; i < RD_LATENCY - 1; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
   end

   assign calib_done        = calib_done_q;
   assign app_rd_data       = rd_data_q;
   assign app_rd_data_valid = rd_valid_q;
   assign app_rd_data_end   = rd_valid_q;
   assign err_cmd           = err_cmd_q;

endmodule

// File: tb/tb_ddr3_ui_responder.sv
// tb/tb_ddr3_ui_responder.sv - directed self-checking bench for ddr3_ui_responder

module tb_ddr3_ui_responder;

   logic         clk;
   logic         reset;
   logic         calib_done;
   logic         app_en;
   logic [2:0]   app_cmd;
   logic [28:0]  app_addr;
   logic         app_rdy;
   logic         app_wdf_wren;
   logic [511:0] app_wdf_data;
   logic         app_wdf_end;
   logic [63:0]  app_wdf_mask;
   logic         app_wdf_rdy;
   logic [511:0] app_rd_data;
   logic         app_rd_data_valid;
   logic         app_rd_data_end;
   logic         err_cmd;

   int checks = 0;
   int errors = 0;

   localparam logic [511:0] PAT_BEEF = {16{32'hDEADBEEF}};
   localparam logic [511:0] PAT_OLD  = {8{64'h0123456789ABCDEF}};
   localparam logic [511:0] PAT_NEW  = {16{32'hCAFEF00D}};
   localparam logic [511:0] PAT_A5   = {64{8'hA5}};

   ddr3_ui_responder dut (
      .clk               (clk),
      .reset             (reset),
      .calib_done        (calib_done),
      .app_en            (app_en),
      .app_cmd           (app_cmd),
      .app_addr          (app_addr),
      .app_rdy           (app_rdy),
      .app_wdf_wren      (app_wdf_wren),
      .app_wdf_data      (app_wdf_data),
      .app_wdf_end       (app_wdf_end),
      .app_wdf_mask      (app_wdf_mask),
      .app_wdf_rdy       (app_wdf_rdy),
      .app_rd_data       (app_rd_data),
      .app_rd_data_valid (app_rd_data_valid),
      .app_rd_data_end   (app_rd_data_end),
      .err_cmd           (err_cmd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [2:0] c, input logic [28:0] a);
      int n = 0;
      app_en = 1'b1; app_cmd = c; app_addr = a;
      while (app_rdy !== 1'b1 && n < 50) begin tick(); n++; end
      checks++;
      if (app_rdy !== 1'b1) begin
         errors++;
         $display("FAIL send_cmd_wait: app_rdy=%b required 1", app_rdy);
      end
      tick();
      app_en = 1'b0;
   endtask

   task automatic send_data(input logic [511:0] d, input logic [63:0] m, input logic e);
      int n = 0;
      app_wdf_wren = 1'b1; app_wdf_data = d; app_wdf_mask = m; app_wdf_end = e;
      while (app_wdf_rdy !== 1'b1 && n < 50) begin tick(); n++; end
      checks++;
      if (app_wdf_rdy !== 1'b1) begin
         errors++;
         $display("FAIL send_data_wait: app_wdf_rdy=%b required 1", app_wdf_rdy);
      end
      tick();
      app_wdf_wren = 1'b0;
   endtask

   task automatic wait_rd(input logic [511:0] exp, input string name);
      int n = 0;
      while (app_rd_data_valid !== 1'b1 && n < 40) begin tick(); n++; end
      checks++;
      if (app_rd_data_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s_valid: got %b required 1", name, app_rd_data_valid);
      end else begin
         checks++;
         if (app_rd_data !== exp) begin
            errors++;
            $display("FAIL %s_data: got %h required %h", name, app_rd_data, exp);
         end
         checks++;
         if (app_rd_data_end !== 1'b1) begin
            errors++;
            $display("FAIL %s_end: got %b required 1", name, app_rd_data_end);
         end
         tick();
         checks++;
         if (app_rd_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_single_pulse: valid got %b required 0", name, app_rd_data_valid);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      checks += 7;
      if (calib_done !== 1'b0)        begin errors++; $display("FAIL rst_calib_done: got %b required 0", calib_done); end
      if (app_rdy !== 1'b0)           begin errors++; $display("FAIL rst_app_rdy: got %b required 0", app_rdy); end
      if (app_wdf_rdy !== 1'b0)       begin errors++; $display("FAIL rst_app_wdf_rdy: got %b required 0", app_wdf_rdy); end
      if (app_rd_data !== '0)         begin errors++; $display("FAIL rst_app_rd_data: got %h required 0", app_rd_data); end
      if (app_rd_data_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid: got %b required 0", app_rd_data_valid); end
      if (app_rd_data_end !== 1'b0)   begin errors++; $display("FAIL rst_rd_end: got %b required 0", app_rd_data_end); end
      if (err_cmd !== 1'b0)           begin errors++; $display("FAIL rst_err_cmd: got %b required 0", err_cmd); end
   endtask

   // Read held on app_en through calibration: accepted in cycle 17, executed
   // two cycles later, valid four cycles after that.
   task automatic test_calibration();
      reset = 1'b0;
      app_en = 1'b1; app_cmd = 3'b001; app_addr = 29'h40;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         checks += 2;
         if (calib_done !== 1'b0) begin errors++; $display("FAIL cal_done_early cycle %0d: got %b required 0", cyc, calib_done); end
         if (app_rdy !== 1'b0)    begin errors++; $display("FAIL cal_rdy_early cycle %0d: got %b required 0", cyc, app_rdy); end
         tick();
      end
      checks += 2;
      if (calib_done !== 1'b1) begin errors++; $display("FAIL cal_done_17: got %b required 1", calib_done); end
      if (app_rdy !== 1'b1)    begin errors++; $display("FAIL cal_rdy_17: got %b required 1", app_rdy); end
      tick();
      app_en = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         checks++;
         if (app_rd_data_valid !== 1'b0) begin errors++; $display("FAIL lat_early +%0d: valid got %b required 0", k, app_rd_data_valid); end
         tick();
      end
      checks += 2;
      if (app_rd_data_valid !== 1'b1) begin errors++; $display("FAIL lat_valid +6: got %b required 1", app_rd_data_valid); end
      if (app_rd_data_end !== 1'b1)   begin errors++; $display("FAIL lat_end +6: got %b required 1", app_rd_data_end); end
      tick();
      checks++;
      if (app_rd_data_valid !== 1'b0) begin errors++; $display("FAIL lat_after +7: valid got %b required 0", app_rd_data_valid); end
   endtask

   task automatic test_write_read();
      send_cmd(3'b000, 29'h10);
      send_data(PAT_BEEF, 64'h0, 1'b1);
      send_cmd(3'b001, 29'h10);
      wait_rd(PAT_BEEF, "wr_rd");
   endtask

   task automatic test_late_data();
      int seen = 0;
      send_cmd(3'b000, 29'h30);
      send_data(PAT_OLD, 64'h0, 1'b1);
      send_cmd(3'b000, 29'h30);
      send_cmd(3'b001, 29'h30);
      for (int k = 0; k < 8; k++) begin
         if (app_rd_data_valid === 1'b1) seen++;
         tick();
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL late_data_blocked: pulses %0d required 0", seen); end
      send_data(PAT_NEW, 64'h0, 1'b1);
      wait_rd(PAT_NEW, "late_data");
   endtask

   task automatic test_byte_mask();
      logic [511:0] exp;
      exp = '0;
      exp[127:0] = '1;
      send_cmd(3'b000, 29'h20);
      send_data('1, 64'h0, 1'b1);
      send_cmd(3'b000, 29'h20);
      send_data('0, 64'h00000000_0000FFFF, 1'b0);
      send_cmd(3'b001, 29'h20);
      wait_rd(exp, "byte_mask");
   endtask

   task automatic test_back_to_back();
      logic [2:0]  c [5];
      logic [28:0] a [5];
      int n = 0;
      int pulses = 0;
      c[0] = 3'b000; a[0] = 29'h000;
      c[1] = 3'b001; a[1] = 29'h000;
      c[2] = 3'b001; a[2] = 29'h800;
      c[3] = 3'b010; a[3] = 29'h000;
      c[4] = 3'b001; a[4] = 29'h805;
      for (int i = 0; i < 4; i++) begin
         app_en = 1'b1; app_cmd = c[i]; app_addr = a[i];
         checks++;
         if (app_rdy !== 1'b1) begin errors++; $display("FAIL b2b_accept %0d: app_rdy %b required 1", i, app_rdy); end
         tick();
      end
      app_cmd = c[4]; app_addr = a[4];
      repeat (2) begin
         checks++;
         if (app_rdy !== 1'b0) begin errors++; $display("FAIL b2b_full: app_rdy %b required 0", app_rdy); end
         tick();
      end
      checks++;
      if (err_cmd !== 1'b0) begin errors++; $display("FAIL b2b_err_early: err_cmd %b required 0", err_cmd); end
      send_data(PAT_A5, 64'h0, 1'b1);
      while (app_rdy !== 1'b1 && n < 50) begin tick(); n++; end
      checks++;
      if (app_rdy !== 1'b1) begin errors++; $display("FAIL b2b_fifth_wait: app_rdy %b required 1", app_rdy); end
      tick();
      app_en = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (app_rd_data_valid === 1'b1) begin
            pulses++;
            checks++;
            if (app_rd_data !== PAT_A5) begin errors++; $display("FAIL b2b_alias_data %0d: got %h required %h", pulses, app_rd_data, PAT_A5); end
         end
         tick();
      end
      checks += 2;
      if (pulses != 3)      begin errors++; $display("FAIL b2b_pulses: got %0d required 3", pulses); end
      if (err_cmd !== 1'b1) begin errors++; $display("FAIL b2b_err_cmd: got %b required 1", err_cmd); end
   endtask

   task automatic test_reset_mid_burst();
      int pulses = 0;
      send_cmd(3'b001, 29'h10);
      send_cmd(3'b001, 29'h10);
      tick();
      reset = 1'b1;
      repeat (2) tick();
      checks += 3;
      if (app_rd_data_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b required 0", app_rd_data_valid); end
      if (err_cmd !== 1'b0)           begin errors++; $display("FAIL mid_rst_err: got %b required 0", err_cmd); end
      if (app_rd_data !== '0)         begin errors++; $display("FAIL mid_rst_data: got %h required 0", app_rd_data); end
      reset = 1'b0;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         if (app_rd_data_valid === 1'b1) pulses++;
         checks++;
         if (calib_done !== 1'b0) begin errors++; $display("FAIL recal_early cycle %0d: got %b required 0", cyc, calib_done); end
         tick();
      end
      checks += 2;
      if (pulses != 0)         begin errors++; $display("FAIL mid_rst_pulses: got %0d required 0", pulses); end
      if (calib_done !== 1'b1) begin errors++; $display("FAIL recal_done: got %b required 1", calib_done); end
      send_cmd(3'b001, 29'h10);
      wait_rd(PAT_BEEF, "retained");
   endtask

   initial begin
      reset = 1'b1;
      app_en = 1'b0; app_cmd = 3'b000; app_addr = '0;
      app_wdf_wren = 1'b0; app_wdf_data = '0; app_wdf_end = 1'b1; app_wdf_mask = '0;
      test_reset();
      test_calibration();
      test_write_read();
      test_late_data();
      test_byte_mask();
      test_back_to_back();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
